// File: rtl/wl_pulse_decoder.sv
// Registered word-line sequencer: latches a {bank,row} request, precharges the
// bit lines, drives a timed one-hot word-line/bank pulse, then strobes DONE.
module wl_pulse_decoder #(
    parameter  int ROW_W     = 4,
    parameter  int BANKS     = 2,
    parameter  int PRE_CYC   = 1,
    parameter  int PULSE_CYC = 2,
    localparam int BW        = (BANKS <= 1) ? 1 : $clog2(BANKS),
    localparam int ROWS      = 2 ** ROW_W
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ,
    input  logic [BW+ROW_W-1:0]   ADR,
    output logic                  READY,
    output logic                  PRE,
    output logic [ROWS-1:0]       WL,
    output logic [BANKS-1:0]      WB,
    output logic                  DONE,
    output logic                  ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRECH = 2'd1;
    localparam logic [1:0] S_ACT   = 2'd2;

    // Counters hold "cycles remaining minus one" so the phase ends on zero.
    localparam logic [3:0] PRE_LAST   = 4'(PRE_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [BW-1:0]      bank_q, bank_d;
    logic               ready_q, ready_d;
    logic               pre_q, pre_d;
    logic [ROWS-1:0]    wl_q, wl_d;
    logic [BANKS-1:0]   wb_q, wb_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [ROW_W-1:0]   adr_row;
    logic [BW-1:0]      adr_bank;

    assign adr_row  = ADR[ROW_W-1:0];
    assign adr_bank = ADR[BW+ROW_W-1:ROW_W];

    function automatic logic [ROWS-1:0] row_onehot(input logic [ROW_W-1:0] r);
        logic [ROWS-1:0] v;
        v = '0;
        v[r] = 1'b1;
        return v;
    endfunction

    function automatic logic [BANKS-1:0] bank_onehot(input logic [BW-1:0] b);
        logic [BANKS-1:0] v;
        v = '0;
        for (int i = 0; i < BANKS; i++) begin
            v[i] = (b == BW'(i));
        end
        return v;
    endfunction

    // The bank field can encode more values than there are banks.
    function automatic logic bank_valid(input logic [BW-1:0] b);
        return ({1'b0, b} < (BW+1)'(BANKS));
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        bank_d  = bank_q;
        ready_d = ready_q;
        pre_d   = pre_q;
        wl_d    = wl_q;
        wb_d    = wb_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    row_d  = adr_row;
                    bank_d = adr_bank;
                    if (!bank_valid(adr_bank)) begin
                        err_d = 1'b1;
                    end else if (PRE_CYC == 0) begin
                        state_d = S_ACT;
                        cnt_d   = PULSE_LAST;
                        ready_d = 1'b0;
                        wl_d    = row_onehot(adr_row);
                        wb_d    = bank_onehot(adr_bank);
                    end else begin
                        state_d = S_PRECH;
                        cnt_d   = PRE_LAST;
                        ready_d = 1'b0;
                        pre_d   = 1'b1;
                    end
                end
            end
            S_PRECH: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACT;
                    cnt_d   = PULSE_LAST;
                    pre_d   = 1'b0;
                    wl_d    = row_onehot(row_q);
                    wb_d    = bank_onehot(bank_q);
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                    ready_d = 1'b1;
                    wl_d    = '0;
                    wb_d    = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
                ready_d = 1'b1;
                pre_d   = 1'b0;
                wl_d    = '0;
                wb_d    = '0;
            end
        endcase
    end

    // Control and output stage: reset clears everything visible to the array.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ready_q <= 1'b1;
            pre_q   <= 1'b0;
            wl_q    <= '0;
            wb_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            pre_q   <= pre_d;
            wl_q    <= wl_d;
            wb_q    <= wb_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Latched address: only meaningful once a request has been accepted.
    always_ff @(posedge CLK) begin
        row_q  <= row_d;
        bank_q <= bank_d;
    end

    assign READY = ready_q;
    assign PRE   = pre_q;
    assign WL    = wl_q;
    assign WB    = wb_q;
    assign DONE  = done_q;
    assign ERR   = err_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (ROW_W >= 1 && BANKS >= 1 && BANKS <= 16 &&
                    PRE_CYC >= 0 && PRE_CYC <= 15 &&
                    PULSE_CYC >= 1 && PULSE_CYC <= 15);
            assert ($onehot0(wl_q));
            assert ($onehot0(wb_q));
            assert (!(pre_q && (wl_q != '0)));
            assert (!(done_q && pre_q));
        end
    end

endmodule

// File: tb/tb_wl_pulse_decoder.sv
// Bench for wl_pulse_decoder: three parameterisations driven with directed and
// random requests, checked every cycle against a timeline model of each access.
module tb_wl_pulse_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [2:0] req_v;
    logic [4:0] adr_a;
    logic [3:0] adr_b, adr_c;

    logic        rdy_a, pre_a, done_a, err_a;
    logic [15:0] wl_a;
    logic [1:0]  wb_a;
    logic        rdy_b, pre_b, done_b, err_b;
    logic [3:0]  wl_b;
    logic [2:0]  wb_b;
    logic        rdy_c, pre_c, done_c, err_c;
    logic [7:0]  wl_c;
    logic [0:0]  wb_c;

    wl_pulse_decoder #(.ROW_W(4), .BANKS(2), .PRE_CYC(1), .PULSE_CYC(2)) dut_a (
        .CLK(clk), .RST(rst), .REQ(req_v[0]), .ADR(adr_a), .READY(rdy_a),
        .PRE(pre_a), .WL(wl_a), .WB(wb_a), .DONE(done_a), .ERR(err_a));
    wl_pulse_decoder #(.ROW_W(2), .BANKS(3), .PRE_CYC(2), .PULSE_CYC(3)) dut_b (
        .CLK(clk), .RST(rst), .REQ(req_v[1]), .ADR(adr_b), .READY(rdy_b),
        .PRE(pre_b), .WL(wl_b), .WB(wb_b), .DONE(done_b), .ERR(err_b));
    wl_pulse_decoder #(.ROW_W(3), .BANKS(1), .PRE_CYC(0), .PULSE_CYC(1)) dut_c (
        .CLK(clk), .RST(rst), .REQ(req_v[2]), .ADR(adr_c), .READY(rdy_c),
        .PRE(pre_c), .WL(wl_c), .WB(wb_c), .DONE(done_c), .ERR(err_c));

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int P [3] = '{1, 2, 0};
    int W [3] = '{2, 3, 1};
    int NB[3] = '{2, 3, 1};
    int RW[3] = '{4, 2, 3};

    // One record per instance: the last accepted access and the last error cycle.
    bit have  [3] = '{0, 0, 0};
    int t0    [3] = '{0, 0, 0};
    int mrow  [3] = '{0, 0, 0};
    int mbank [3] = '{0, 0, 0};
    int err_at[3] = '{-1, -1, -1};

    task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", nm, i, cyc, got, exp);
        end
    endtask

    function automatic int adr_of(int i);
        case (i)
            0:       return int'(adr_a);
            1:       return int'(adr_b);
            default: return int'(adr_c);
        endcase
    endfunction

    function automatic bit ready_exp(int i, int n);
        return !have[i] || (n >= t0[i] + P[i] + W[i] + 1);
    endfunction

    // Model update at each edge; edge k ends cycle k and starts cycle k+1.
    always @(posedge clk) begin
        int k;
        k = cyc;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                have[i]   = 1'b0;
                err_at[i] = -1;
            end else if (req_v[i] && ready_exp(i, k)) begin
                int a, r, b;
                a = adr_of(i);
                r = a % (1 << RW[i]);
                b = a >> RW[i];
                if (b >= NB[i]) begin
                    err_at[i] = k + 1;
                end else begin
                    have[i]  = 1'b1;
                    t0[i]    = k;
                    mrow[i]  = r;
                    mbank[i] = b;
                end
            end
        end
        cyc = k + 1;
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            for (int i = 0; i < 3; i++) begin
                logic [31:0] g_rdy, g_pre, g_wl, g_wb, g_done, g_err;
                logic [31:0] e_wl, e_wb;
                bit e_pre, e_act, e_done;
                int n;
                n = cyc;
                case (i)
                    0: begin
                        g_rdy = 32'(rdy_a); g_pre = 32'(pre_a); g_wl = 32'(wl_a);
                        g_wb = 32'(wb_a); g_done = 32'(done_a); g_err = 32'(err_a);
                    end
                    1: begin
                        g_rdy = 32'(rdy_b); g_pre = 32'(pre_b); g_wl = 32'(wl_b);
                        g_wb = 32'(wb_b); g_done = 32'(done_b); g_err = 32'(err_b);
                    end
                    default: begin
                        g_rdy = 32'(rdy_c); g_pre = 32'(pre_c); g_wl = 32'(wl_c);
                        g_wb = 32'(wb_c); g_done = 32'(done_c); g_err = 32'(err_c);
                    end
                endcase
                e_pre  = have[i] && n >= t0[i] + 1 && n <= t0[i] + P[i];
                e_act  = have[i] && n >= t0[i] + P[i] + 1 && n <= t0[i] + P[i] + W[i];
                e_done = have[i] && n == t0[i] + P[i] + W[i] + 1;
                e_wl   = e_act ? (32'd1 << mrow[i]) : 32'd0;
                e_wb   = e_act ? (32'd1 << mbank[i]) : 32'd0;
                cmp("READY", i, g_rdy, 32'(ready_exp(i, n)));
                cmp("PRE", i, g_pre, 32'(e_pre));
                cmp("WL", i, g_wl, e_wl);
                cmp("WB", i, g_wb, e_wb);
                cmp("DONE", i, g_done, 32'(e_done));
                cmp("ERR", i, g_err, 32'(n == err_at[i]));
            end
        end
    end

    initial begin
        rst   = 1'b1;
        req_v = 3'b111;
        adr_a = 5'h13;
        adr_b = 4'h0;
        adr_c = 4'h0;

        // Reset held three cycles with requests asserted.
        repeat (3) begin
            @(negedge clk);
            cmp("lit_rst_ready", 0, 32'(rdy_a), 32'd1);
            cmp("lit_rst_wl", 0, 32'(wl_a), 32'd0);
            cmp("lit_rst_done", 0, 32'(done_a), 32'd0);
        end
        rst   = 1'b0;
        req_v = 3'b000;

        // Single access then back-to-back on the default instance.
        @(negedge clk);
        req_v[0] = 1'b1;
        adr_a    = 5'h13;
        @(negedge clk);
        cmp("lit_a1_pre", 0, 32'(pre_a), 32'd1);
        cmp("lit_a1_ready", 0, 32'(rdy_a), 32'd0);
        adr_a = 5'h0F;
        @(negedge clk);
        cmp("lit_a2_wl", 0, 32'(wl_a), 32'h0008);
        cmp("lit_a2_wb", 0, 32'(wb_a), 32'h2);
        @(negedge clk);
        cmp("lit_a3_wl", 0, 32'(wl_a), 32'h0008);
        cmp("lit_a3_ready", 0, 32'(rdy_a), 32'd0);
        @(negedge clk);
        cmp("lit_a4_done", 0, 32'(done_a), 32'd1);
        cmp("lit_a4_ready", 0, 32'(rdy_a), 32'd1);
        @(negedge clk);
        cmp("lit_a5_pre", 0, 32'(pre_a), 32'd1);
        cmp("lit_a5_done", 0, 32'(done_a), 32'd0);
        req_v[0] = 1'b0;
        @(negedge clk);
        cmp("lit_a6_wl", 0, 32'(wl_a), 32'h8000);
        cmp("lit_a6_wb", 0, 32'(wb_a), 32'h1);
        @(negedge clk);
        cmp("lit_a7_wl", 0, 32'(wl_a), 32'h8000);
        @(negedge clk);
        cmp("lit_a8_done", 0, 32'(done_a), 32'd1);

        // Out-of-range bank on the three-bank instance.
        @(negedge clk);
        req_v[1] = 1'b1;
        adr_b    = 4'hD;
        @(negedge clk);
        req_v[1] = 1'b0;
        cmp("lit_b_err", 1, 32'(err_b), 32'd1);
        cmp("lit_b_ready", 1, 32'(rdy_b), 32'd1);
        cmp("lit_b_pre", 1, 32'(pre_b), 32'd0);
        @(negedge clk);
        cmp("lit_b_err_off", 1, 32'(err_b), 32'd0);
        cmp("lit_b_done", 1, 32'(done_b), 32'd0);

        // No precharge, single pulse cycle.
        @(negedge clk);
        req_v[2] = 1'b1;
        adr_c    = 4'h5;
        @(negedge clk);
        req_v[2] = 1'b0;
        cmp("lit_c_wl", 2, 32'(wl_c), 32'h20);
        cmp("lit_c_wb", 2, 32'(wb_c), 32'h1);
        cmp("lit_c_pre", 2, 32'(pre_c), 32'd0);
        @(negedge clk);
        cmp("lit_c_done", 2, 32'(done_c), 32'd1);
        cmp("lit_c_wl_off", 2, 32'(wl_c), 32'd0);

        // Reset during the first word-line cycle aborts the access.
        @(negedge clk);
        req_v[0] = 1'b1;
        adr_a    = 5'h02;
        @(negedge clk);
        req_v[0] = 1'b0;
        @(negedge clk);
        cmp("lit_r_wl", 0, 32'(wl_a), 32'h0004);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        cmp("lit_r_wl_off", 0, 32'(wl_a), 32'd0);
        cmp("lit_r_wb_off", 0, 32'(wb_a), 32'd0);
        cmp("lit_r_ready", 0, 32'(rdy_a), 32'd1);
        @(negedge clk);
        cmp("lit_r_nodone", 0, 32'(done_a), 32'd0);

        // Random traffic with occasional resets.
        repeat (3000) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 149) == 0);
            req_v = 3'($urandom);
            adr_a = 5'($urandom);
            adr_b = 4'($urandom);
            adr_c = 4'($urandom);
        end
        @(negedge clk);
        rst   = 1'b0;
        req_v = 3'b000;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
